dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate L1 data cache controller between the pipeline's MEM stage and the backing data memory. It is the initiator side of the data-memory interface: it answers CPU loads from local storage, refills missing lines word by word from memory, and forwards every store to memory. The CPU is held with `cpu_stall` while a refill or write-through is outstanding.

---
 rtl/dcache_ctrl_pkg.sv | 17 +
 rtl/dcache_ctrl_array.sv | 63 ++++++
 rtl/dcache_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: shared constants and the controller state encoding for
// the direct-mapped write-through L1 data cache.
package dcache_ctrl_pkg;

  localparam int unsigned DC_DATA_BITS   = 32;
  localparam int unsigned DC_INDEX_BITS  = 6;
  localparam int unsigned DC_OFFSET_BITS = 2;
  localparam int unsigned DC_ADDR_W      = DC_DATA_BITS - 2;

  // Controller states (2-bit encoding).
  typedef enum logic [1:0] {
    DC_IDLE   = 2'd0,
    DC_REFILL = 2'd1,
    DC_WRITE  = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_ctrl_array.sv
// dcache_array: valid/tag/data storage for the direct-mapped data cache.
//   rd_*    combinational read of valid bit, tag and one data word
//   wr_*    synchronous single-word data write
//   fill_*  synchronous tag write + valid set (line completion)
//   inv_*   synchronous valid clear
//   reset   asynchronous active-low, clears every valid bit
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = DC_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = DC_OFFSET_BITS,
  parameter int unsigned TAG_W       = DC_ADDR_W - DC_INDEX_BITS - DC_OFFSET_BITS,
  parameter int unsigned DATA_W      = DC_DATA_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [DATA_W-1:0]      rd_word,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [DATA_W-1:0]      wr_word,
  input  logic                   fill_en,
  input  logic [INDEX_BITS-1:0]  fill_index,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic                   inv_en,
  input  logic [INDEX_BITS-1:0]  inv_index
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned WORDS = LINES << OFFSET_BITS;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [WORDS];

  // Valid bit next-state: clear on refill entry, set on line completion.
  always_comb begin
    valid_d = valid_q;
    if (inv_en)  valid_d[inv_index]  = 1'b0;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data storage; contents are only meaningful under a set valid bit.
  always_ff @(posedge clock) begin
    if (fill_en) tag_q[fill_index] <= fill_tag;
    if (wr_en)   data_q[{wr_index, wr_offset}] <= wr_word;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate L1 data cache
// controller between the MEM stage and data memory.
//   cpu_ren/cpu_wen/cpu_addr/cpu_din  CPU request (held while cpu_stall)
//   cpu_dout/cpu_stall                load data (IDLE read hit only) and stall
//   mem_ren/mem_wen/mem_addr/mem_din  registered memory request
//   mem_dout/mem_ready                memory read data and beat completion
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = DC_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = DC_OFFSET_BITS,
  parameter int unsigned ADDR_W      = DC_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              cpu_stall,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINE_W = ADDR_W - OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'((1 << OFFSET_BITS) - 1);

  dc_state_e               state_q, state_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [ADDR_W-1:0]       wb_addr_q, wb_addr_d;
  logic [31:0]             wb_data_q, wb_data_d;
  logic                    mem_ren_q, mem_ren_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [31:0]             mem_din_q, mem_din_d;

  logic [ADDR_W-1:0]       rd_addr;
  logic [INDEX_BITS-1:0]   rd_index;
  logic [OFFSET_BITS-1:0]  rd_offset;
  logic [TAG_W-1:0]        rd_tag_req;
  logic                    arr_valid;
  logic [TAG_W-1:0]        arr_tag;
  logic [31:0]             arr_word;
  logic                    hit;
  logic [INDEX_BITS-1:0]   line_index;
  logic [TAG_W-1:0]        line_tag;

  logic                    wr_en;
  logic [INDEX_BITS-1:0]   wr_index;
  logic [OFFSET_BITS-1:0]  wr_offset;
  logic [31:0]             wr_word;
  logic                    fill_en;
  logic                    inv_en;

  // Lookup address: the buffered store while in WRITE, else the CPU request.
  assign rd_addr    = (state_q == DC_WRITE) ? wb_addr_q : cpu_addr;
  assign rd_offset  = rd_addr[OFFSET_BITS-1:0];
  assign rd_index   = rd_addr[OFFSET_BITS +: INDEX_BITS];
  assign rd_tag_req = rd_addr[ADDR_W-1 -: TAG_W];
  assign hit        = arr_valid && (arr_tag == rd_tag_req);
  assign line_index = line_q[INDEX_BITS-1:0];
  assign line_tag   = line_q[LINE_W-1 -: TAG_W];

  dcache_array #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_W       (TAG_W),
    .DATA_W      (32)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (rd_index),
    .rd_offset  (rd_offset),
    .rd_valid   (arr_valid),
    .rd_tag     (arr_tag),
    .rd_word    (arr_word),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_offset  (wr_offset),
    .wr_word    (wr_word),
    .fill_en    (fill_en),
    .fill_index (line_index),
    .fill_tag   (line_tag),
    .inv_en     (inv_en),
    .inv_index  (rd_index)
  );

  // Next-state, array control and CPU-side outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    mem_ren_d  = 1'b0;
    mem_wen_d  = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    cpu_stall  = 1'b0;
    cpu_dout   = '0;
    wr_en      = 1'b0;
    wr_index   = line_index;
    wr_offset  = cnt_q;
    wr_word    = mem_dout;
    fill_en    = 1'b0;
    inv_en     = 1'b0;

    unique case (state_q)
      DC_IDLE: begin
        if (cpu_wen) begin
          // A store wins over a simultaneous load.
          wb_addr_d  = cpu_addr;
          wb_data_d  = cpu_din;
          cpu_stall  = 1'b1;
          state_d    = DC_WRITE;
          mem_wen_d  = 1'b1;
          mem_addr_d = cpu_addr;
          mem_din_d  = cpu_din;
        end else if (cpu_ren) begin
          if (hit) begin
            cpu_dout = arr_word;
          end else begin
            // Invalidate now so a partially refilled line never hits.
            line_d     = cpu_addr[ADDR_W-1:OFFSET_BITS];
            cnt_d      = '0;
            cpu_stall  = 1'b1;
            inv_en     = 1'b1;
            state_d    = DC_REFILL;
            mem_ren_d  = 1'b1;
            mem_addr_d = {cpu_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
      end

      DC_REFILL: begin
        cpu_stall  = 1'b1;
        mem_ren_d  = 1'b1;
        mem_addr_d = {line_q, cnt_q};
        if (mem_ready) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + OFFSET_BITS'(1);
          if (cnt_q == LAST_BEAT) begin
            fill_en    = 1'b1;
            state_d    = DC_IDLE;
            mem_ren_d  = 1'b0;
            mem_addr_d = '0;
          end else begin
            mem_addr_d = {line_q, cnt_q + OFFSET_BITS'(1)};
          end
        end
      end

      DC_WRITE: begin
        cpu_stall  = !mem_ready;
        mem_wen_d  = 1'b1;
        mem_addr_d = wb_addr_q;
        mem_din_d  = wb_data_q;
        if (mem_ready) begin
          // Write-through: refresh the cached copy only on a hit.
          wr_en      = hit;
          wr_index   = rd_index;
          wr_offset  = rd_offset;
          wr_word    = wb_data_q;
          state_d    = DC_IDLE;
          mem_wen_d  = 1'b0;
          mem_addr_d = '0;
          mem_din_d  = '0;
        end
      end

      default: begin
        state_d = DC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= DC_IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign mem_ren  = mem_ren_q;
  assign mem_wen  = mem_wen_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a small word-addressed
// memory model (initial contents 0x1000+addr, programmable ready delay).
module tb_dcache_ctrl;

  localparam int unsigned ADDR_W = 30;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_ren;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_din;
  logic [31:0]       cpu_dout;
  logic              cpu_stall;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic              mem_ready;

  always #5 clock = ~clock;

  dcache_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_stall (cpu_stall),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready)
  );

  // Memory model: ready after ready_delay cycles of an active request.
  logic [31:0]       mem [2048];
  bit                mem_init;
  int                wait_cnt;
  int                ready_delay;
  logic [ADDR_W-1:0] beat_log [64];
  int                beat_total;
  int                wr_total;

  assign mem_ready = (mem_ren || mem_wen) && (wait_cnt >= ready_delay - 1);
  assign mem_dout  = mem[mem_addr[10:0]];

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h1000 + 32'(i);
      mem_init <= 1'b1;
    end
    if (mem_ren || mem_wen) begin
      if (mem_ready) begin
        wait_cnt <= 0;
        if (mem_wen) begin
          mem[mem_addr[10:0]] <= mem_din;
          wr_total <= wr_total + 1;
        end else begin
          beat_log[beat_total % 64] <= mem_addr;
          beat_total <= beat_total + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Load: hold the request until stall drops, then check data, latency, beats.
  task automatic do_read(input string name, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] exp_data, input int exp_lat,
                         input int exp_beats, input logic [ADDR_W-1:0] base);
    int b0;
    int cyc;
    b0 = beat_total;
    @(posedge clock); #1;
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = addr;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (!cpu_stall) break;
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " cpu_dout"}, cpu_dout, exp_data);
    check({name, " mem_ren at hit"}, 32'(mem_ren), 32'd0);
    check({name, " beat count"}, 32'(beat_total - b0), 32'(exp_beats));
    for (int i = 0; i < exp_beats; i++)
      check({name, " beat addr"}, 32'(beat_log[(b0 + i) % 64]), 32'(base) + 32'(i));
    @(posedge clock); #1;
    cpu_ren = 1'b0;
  endtask

  // Store: check stall length, stable write request, write-through, no refill.
  task automatic do_write(input string name, input logic ren_too, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] data, input int delay);
    int w0;
    int b0;
    int cyc;
    int nst;
    logic stable;
    w0 = wr_total;
    b0 = beat_total;
    ready_delay = delay;
    @(posedge clock); #1;
    cpu_ren = ren_too; cpu_wen = 1'b1; cpu_addr = addr; cpu_din = data;
    cyc = 0; nst = 0; stable = 1'b1;
    while (cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (cpu_stall) nst++;
      if (cyc > 1)
        stable = stable && mem_wen && !mem_ren && (mem_addr == addr) && (mem_din == data);
      if (!cpu_stall) break;
    end
    check({name, " stall cycles"}, 32'(nst), 32'(delay));
    check({name, " request stable"}, 32'(stable), 32'd1);
    @(posedge clock); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    check({name, " mem writes"}, 32'(wr_total - w0), 32'd1);
    check({name, " mem contents"}, mem[addr[10:0]], data);
    check({name, " no refill"}, 32'(beat_total - b0), 32'd0);
    ready_delay = 1;
  endtask

  typedef struct {
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic              exp_stall;
    logic [31:0]       exp_dout;
    logic              exp_mem_ren;
  } vec_t;

  vec_t vecs [6];
  int   b0_main;
  int   cyc_main;

  initial begin
    vecs[0] = '{ren: 1'b1, wen: 1'b0, addr: 30'h013, exp_stall: 1'b0, exp_dout: 32'h1013, exp_mem_ren: 1'b0};
    vecs[1] = '{ren: 1'b1, wen: 1'b0, addr: 30'h010, exp_stall: 1'b0, exp_dout: 32'h1010, exp_mem_ren: 1'b0};
    vecs[2] = '{ren: 1'b1, wen: 1'b0, addr: 30'h011, exp_stall: 1'b0, exp_dout: 32'h1011, exp_mem_ren: 1'b0};
    vecs[3] = '{ren: 1'b1, wen: 1'b0, addr: 30'h012, exp_stall: 1'b0, exp_dout: 32'h1012, exp_mem_ren: 1'b0};
    vecs[4] = '{ren: 1'b0, wen: 1'b0, addr: 30'h013, exp_stall: 1'b0, exp_dout: 32'h0, exp_mem_ren: 1'b0};
    vecs[5] = '{ren: 1'b0, wen: 1'b0, addr: 30'h000, exp_stall: 1'b0, exp_dout: 32'h0, exp_mem_ren: 1'b0};

    reset = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_din = '0;
    ready_delay = 1;

    // Outputs while reset is held.
    repeat (2) @(negedge clock);
    check("reset mem_ren", 32'(mem_ren), 32'd0);
    check("reset mem_wen", 32'(mem_wen), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_din", mem_din, 32'd0);
    check("reset cpu_dout", cpu_dout, 32'd0);
    check("reset cpu_stall", 32'(cpu_stall), 32'd0);
    @(negedge clock); reset = 1'b1;

    // Cold miss: detect + 4 beats + hit cycle.
    do_read("cold miss 0x010", 30'h010, 32'h1010, 6, 4, 30'h010);

    // Single-cycle vectors against the freshly filled line.
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      cpu_ren = vecs[i].ren; cpu_wen = vecs[i].wen; cpu_addr = vecs[i].addr;
      @(negedge clock);
      check($sformatf("vec%0d stall", i), 32'(cpu_stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d dout", i), cpu_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d mem_ren", i), 32'(mem_ren), 32'(vecs[i].exp_mem_ren));
    end
    @(posedge clock); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;

    // Store hit with slow memory, then the cached word reflects it.
    do_write("store hit 0x012", 1'b0, 30'h012, 32'hDEADBEEF, 3);
    do_read("read 0x012 after store", 30'h012, 32'hDEADBEEF, 1, 0, 30'h0);

    // Store miss: no allocate, resident line untouched.
    do_write("store miss 0x412", 1'b0, 30'h412, 32'h00000055, 1);
    do_read("read 0x010 after store miss", 30'h010, 32'h1010, 1, 0, 30'h0);

    // Conflict miss evicts index 4; the old line then misses again.
    do_read("conflict 0x410", 30'h410, 32'h1410, 6, 4, 30'h410);
    do_read("read 0x412 from refill", 30'h412, 32'h00000055, 1, 0, 30'h0);
    do_read("re-miss 0x010", 30'h010, 32'h1010, 6, 4, 30'h010);
    do_read("read 0x012 from memory", 30'h012, 32'hDEADBEEF, 1, 0, 30'h0);

    // Simultaneous load+store is a store.
    do_write("ren+wen 0x013", 1'b1, 30'h013, 32'h00000077, 1);
    do_read("read 0x013 after ren+wen", 30'h013, 32'h00000077, 1, 0, 30'h0);

    // Reset in the middle of a refill.
    b0_main = beat_total;
    @(posedge clock); #1;
    cpu_ren = 1'b1; cpu_addr = 30'h410;
    cyc_main = 0;
    while (cyc_main < 40 && (beat_total - b0_main) < 2) begin
      @(negedge clock);
      cyc_main++;
    end
    check("midreset beats before reset", 32'(beat_total - b0_main), 32'd2);
    check("midreset mem_ren before reset", 32'(mem_ren), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset mem_ren", 32'(mem_ren), 32'd0);
    check("midreset mem_addr", 32'(mem_addr), 32'd0);
    check("midreset cpu_dout", cpu_dout, 32'd0);
    check("midreset mem_wen", 32'(mem_wen), 32'd0);
    cpu_ren = 1'b0;
    @(negedge clock); reset = 1'b1;
    do_read("post-reset miss 0x010", 30'h010, 32'h1010, 6, 4, 30'h010);
    do_read("post-reset read 0x013", 30'h013, 32'h00000077, 1, 0, 30'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
